// File: rtl/sram_be_clr.sv
// Single-port SRAM with per-byte write enables and a sequential clear engine.
// The array is zeroed one word per cycle after reset or on clr; accesses wait for it.
module sram_be_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                res,
    input  logic                req,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    output logic [DATA_W-1:0]   data_out,
    output logic                rvalid,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_nxt;
    logic                clr_we;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            CLEAR: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (&cnt) state_nxt = READY;
            end
            READY: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // clr takes priority over any access issued in the same cycle
    assign clr_we = (state == CLEAR) && !res;
    assign wr_en  = (state == READY) && !clr && req && WE;
    assign rd_en  = (state == READY) && !clr && req && !WE;
    assign busy   = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_out <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) data_out <= mem[addr];
        end
    end

endmodule

// File: tb/tb_sram_be_clr.sv
// Directed bench for sram_be_clr: vector table for READY-state accesses
// plus hand sequences for reset, clr and clear-abort cases.
module tb_sram_be_clr;

    logic        clk = 1'b0;
    logic        res;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  be;
    logic        clr;
    logic [31:0] data_out;
    logic        rvalid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_be_clr #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .WE      (we),
        .addr    (addr),
        .data_in (data_in),
        .be      (be),
        .clr     (clr),
        .data_out(data_out),
        .rvalid  (rvalid),
        .busy    (busy)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        rv;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; clr = 1'b0;
        addr = '0; data_in = '0; be = '0;
    endtask

    task automatic cyc(input logic r, input logic w, input logic c,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        req = r; we = w; clr = c; addr = a; data_in = d; be = b;
        @(posedge clk);
        #1;
    endtask

    // counts edges until busy falls; flags any rvalid seen meanwhile
    task automatic wait_clear(output int n, output logic rv_seen);
        n = 0;
        rv_seen = 1'b0;
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (rvalid !== 1'b0) rv_seen = 1'b1;
        end
    endtask

    int   n;
    logic rv_seen;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'h0, 1'b1, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vecs[5]  = '{1'b1, 1'b1, 8'h30, 32'hFFFFFFFF, 4'h0, 1'b0, 32'hDE22BE44};
        vecs[6]  = '{1'b1, 1'b0, 8'h30, 32'h0,        4'h0, 1'b1, 32'h00000000};
        vecs[7]  = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vecs[8]  = '{1'b0, 1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'hDE22BE44};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF, 32'hAABBCCDD, 4'h8, 1'b0, 32'hDE22BE44};
        vecs[10] = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'h0, 1'b1, 32'hAA000000};
        vecs[11] = '{1'b1, 1'b1, 8'h00, 32'h12345678, 4'h3, 1'b0, 32'hAA000000};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 32'h00005678};

        // asynchronous reset state
        res = 1'b1;
        idle();
        #3;
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_dout", data_out, 32'h0);

        // write attempted throughout the initial clear must be ignored
        @(negedge clk);
        res = 1'b0;
        req = 1'b1; we = 1'b1; addr = 8'h20; data_in = 32'hCAFEF00D; be = 4'hF;
        wait_clear(n, rv_seen);
        idle();
        check("init_clear_edges", 32'(n), 32'd256);
        check("init_clear_rvalid", 32'(rv_seen), 32'h0);
        check("init_busy_low", 32'(busy), 32'h0);

        cyc(1'b1, 1'b0, 1'b0, 8'h20, 32'h0, 4'h0);
        check("busy_write_dropped", data_out, 32'h0);
        check("busy_write_rvalid", 32'(rvalid), 32'h1);

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].req, vecs[i].we, 1'b0, vecs[i].addr,
                vecs[i].din, vecs[i].be);
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end
        idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        check("idle_rvalid", 32'(rvalid), 32'h0);

        // clr wins over a simultaneous write
        cyc(1'b1, 1'b1, 1'b1, 8'h10, 32'hFFFFFFFF, 4'hF);
        idle();
        check("clr_busy", 32'(busy), 32'h1);
        check("clr_rvalid", 32'(rvalid), 32'h0);
        wait_clear(n, rv_seen);
        check("clr_edges", 32'(n), 32'd256);
        check("clr_no_rvalid", 32'(rv_seen), 32'h0);
        check("clr_dout_hold", data_out, 32'h00005678);
        cyc(1'b1, 1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
        check("clr_read_10", data_out, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF, 32'h0, 4'h0);
        check("clr_read_ff", data_out, 32'h0);

        // reset during a read result cycle
        cyc(1'b1, 1'b1, 1'b0, 8'h40, 32'h5A5A5A5A, 4'hF);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
        idle();
        check("pre_res_dout", data_out, 32'h5A5A5A5A);
        check("pre_res_rvalid", 32'(rvalid), 32'h1);
        res = 1'b1;
        #1;
        check("res_access_busy", 32'(busy), 32'h1);
        check("res_access_rvalid", 32'(rvalid), 32'h0);
        check("res_access_dout", data_out, 32'h0);
        @(negedge clk);
        res = 1'b0;
        wait_clear(n, rv_seen);
        check("res_access_edges", 32'(n), 32'd256);

        // reset when cnt reaches 100 mid-clear
        cyc(1'b0, 1'b0, 1'b1, 8'h0, 32'h0, 4'h0);
        idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
        end
        #1;
        check("mid_clear_busy", 32'(busy), 32'h1);
        res = 1'b1;
        #1;
        check("res_mid_busy", 32'(busy), 32'h1);
        check("res_mid_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        res = 1'b0;
        wait_clear(n, rv_seen);
        check("res_mid_edges", 32'(n), 32'd256);
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
        idle();
        check("res_mid_read_40", data_out, 32'h0);
        check("res_mid_read_rv", 32'(rvalid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_be_clr.md
SRAM_BE_CLR -- requirements
Module: sram_be_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port res, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port req, input, 1, access request, sampled at the rising edge of clk.
REQ-006 SHALL have port WE, input, 1, qualifies req: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, ADDR_W, word address.
REQ-008 SHALL have port data_in, input, DATA_W, write data.
REQ-009 SHALL have port be, input, DATA_W/8, byte enables; be[i] covers data_in[8i+7:8i].
REQ-010 SHALL have port clr, input, 1, synchronous request to zero the whole array.
REQ-011 SHALL have port data_out, output, DATA_W, registered read data.
REQ-012 SHALL have port rvalid, output, 1, one-cycle pulse marking new data_out.
REQ-013 SHALL have port busy, output, 1, high while the array is being cleared.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 In CLEAR, each cycle SHALL write all-zero to mem[cnt] and increment the ADDR_W-bit counter cnt, starting at cnt=0.
REQ-016 In CLEAR with cnt = DEPTH-1, SHALL perform the final zero write and move to READY on the same edge.
REQ-017 busy SHALL equal 1 exactly while state is CLEAR, so busy is high for DEPTH rising edges per clear pass.
REQ-018 In CLEAR, req, WE and clr SHALL be ignored, with no memory access and no rvalid pulse.
REQ-019 In READY, req=1 with WE=1 SHALL write every byte i of mem[addr] with be[i]=1 and leave bytes with be[i]=0 unchanged.
REQ-020 A write with be=0 SHALL leave memory unchanged and SHALL NOT raise rvalid.
REQ-021 In READY, req=1 with WE=0 SHALL load mem[addr] into data_out at that edge and set rvalid=1 for exactly that following cycle (read latency 1).
REQ-022 rvalid SHALL be 0 in every cycle not immediately after a read edge; back-to-back reads SHALL keep rvalid high continuously.
REQ-023 data_out SHALL hold its last value when no read occurs, including across writes and clear passes.
REQ-024 A read at edge N+1 of an address written at edge N SHALL return the newly written bytes.
REQ-025 In READY, clr=1 SHALL move the FSM to CLEAR with cnt=0 at that edge; a req in the same cycle SHALL be dropped (clr wins).
REQ-026 The address space is exactly DEPTH words; every addr value is valid and there SHALL be no wrap or alias logic.

Reset
REQ-027 res=1 SHALL immediately and asynchronously force state=CLEAR, cnt=0, busy=1, rvalid=0 and data_out=0.
REQ-028 Memory contents SHALL NOT be reset asynchronously; they are zeroed only by the CLEAR pass.
REQ-029 The CLEAR pass SHALL begin at the first rising edge of clk where res=0.
REQ-030 res asserted mid-clear or mid-access SHALL abort the operation and restart the clear pass from cnt=0 after release.

Verification (DATA_W=32, ADDR_W=8)
REQ-031 Release res -> busy=1 for exactly 256 edges then 0; read of addr 0xFF -> data_out=0x00000000, rvalid=1 for one cycle.
REQ-032 Write 0xDEADBEEF, be=4'b1111, addr 0x10, then read 0x10 -> data_out=0xDEADBEEF one cycle after the read edge.
REQ-033 Write 0x11223344, be=4'b0101, to addr 0x10 (holding 0xDEADBEEF), then read -> 0xDE22BE44.
REQ-034 Write 0xCAFEF00D to addr 0x20 while busy=1, then read 0x20 after busy falls -> 0x00000000, and no rvalid during busy.
REQ-035 clr=1 with req=1/WE=1 in READY -> the write is dropped, busy=1 for 256 edges, and a later read of 0x10 -> 0x00000000.
REQ-036 Assert res when cnt=100 during CLEAR -> busy and rvalid immediately 1 and 0 respectively, then after release busy stays high for a full 256 edges.
